spi_flash_sequencer: RTL

//  Command-level controller for the configuration SPI flash byte shifter. Takes one

---
 rtl/spi_flash_sequencer_if.sv | 45 ++++
 rtl/spi_flash_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_sequencer_if.sv
// Bundle of the sequencer's command, write, read, shifter, chip-select and
// status signals.
//   master : command source, write/read streams, byte-shifter responses, abort
//   slave  : spi_flash_sequencer (command accept, shifter requests, cs_n, status)
interface spi_flash_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic [23:0] cmd_addr;
   logic        cmd_has_addr;
   logic [15:0] cmd_len;
   logic        cmd_read;
   logic        cmd_wren;
   logic        cmd_poll;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        sh_start;
   logic [7:0]  sh_tx;
   logic        sh_done;
   logic [7:0]  sh_rx;
   logic        cs_n;
   logic        abort;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  status;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_has_addr, cmd_len, cmd_read,
             cmd_wren, cmd_poll, wr_data, wr_valid, rd_ready, sh_done, sh_rx, abort,
      input  cmd_ready, wr_ready, rd_data, rd_valid, sh_start, sh_tx, cs_n,
             busy, done, err, status
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_has_addr, cmd_len, cmd_read,
             cmd_wren, cmd_poll, wr_data, wr_valid, rd_ready, sh_done, sh_rx, abort,
      output cmd_ready, wr_ready, rd_data, rd_valid, sh_start, sh_tx, cs_n,
             busy, done, err, status
   );
endinterface

// File: rtl/spi_flash_sequencer.sv
// Command-level SPI flash sequencer. Frames one descriptor (opcode, optional
// 24-bit address, N data bytes) with chip select, optionally prefixes WREN and
// follows with RDSR polling until WIP clears. The byte shifter owns bit timing.
//   clk, rst : bus clock, asynchronous active-high reset
//   bus      : spi_flash_sequencer_if.slave (command, wr/rd streams, shifter, cs_n, status)
//
// state  | meaning
// IDLE   | waiting for a descriptor
// WREN   | one-byte 0x06 frame
// GAP_A  | cs_n high between WREN and main frame
// OP     | opcode byte of main frame
// ADDR   | three address bytes, MSB first
// DATA   | data phase, read or write
// GAP_B  | cs_n high after main frame
// POLL   | RDSR frame (0x05, 0x00)
// GAP_P  | cs_n high between RDSR frames
// FIN    | done pulse, back to IDLE
module spi_flash_sequencer #(
   parameter int CS_GAP   = 4,
   parameter int POLL_MAX = 2000000
) (
   input logic                  clk,
   input logic                  rst,
   spi_flash_sequencer_if.slave bus
);
   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam int PW = $clog2(POLL_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WREN, S_GAP_A, S_OP, S_ADDR, S_DATA, S_GAP_B, S_POLL, S_GAP_P, S_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    op_q, op_d;
   logic [23:0]   addr_q, addr_d;
   logic          has_addr_q, has_addr_d;
   logic [15:0]   len_q, len_d;
   logic          read_q, read_d;
   logic          poll_q, poll_d;
   logic          cs_n_q, cs_n_d;
   logic          pend_q, pend_d;
   logic [1:0]    idx_q, idx_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [PW-1:0] poll_left_q, poll_left_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic [7:0]    status_q, status_d;
   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;

   logic          cmd_ready, sh_start, wr_ready, done, can_start, frame_end;
   logic [7:0]    sh_tx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         has_addr_q  <= 1'b0;
         len_q       <= '0;
         read_q      <= 1'b0;
         poll_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         pend_q      <= 1'b0;
         idx_q       <= '0;
         gap_q       <= '0;
         poll_left_q <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         status_q    <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         has_addr_q  <= has_addr_d;
         len_q       <= len_d;
         read_q      <= read_d;
         poll_q      <= poll_d;
         cs_n_q      <= cs_n_d;
         pend_q      <= pend_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         poll_left_q <= poll_left_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         status_q    <= status_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      has_addr_d  = has_addr_q;
      len_d       = len_q;
      read_d      = read_q;
      poll_d      = poll_q;
      cs_n_d      = cs_n_q;
      idx_d       = idx_q;
      poll_left_d = poll_left_q;
      busy_d      = busy_q;
      err_d       = err_q;
      status_d    = status_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      frame_end   = 1'b0;
      pend_d      = pend_q;
      if (bus.sh_done) pend_d = 1'b0;
      if (sh_start)    pend_d = 1'b1;
      if (rd_valid_q && bus.rd_ready) rd_valid_d = 1'b0;
      gap_d = gap_q;
      if (gap_q != '0) gap_d = gap_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               op_d        = bus.cmd_op;
               addr_d      = bus.cmd_addr;
               has_addr_d  = bus.cmd_has_addr;
               len_d       = bus.cmd_len;
               read_d      = bus.cmd_read;
               poll_d      = bus.cmd_poll;
               idx_d       = '0;
               poll_left_d = PW'(POLL_MAX);
               busy_d      = 1'b1;
               err_d       = 1'b0;
               state_d     = bus.cmd_wren ? S_WREN : S_OP;
            end
         end
         S_WREN: begin
            cs_n_d = 1'b0;
            if (bus.sh_done) begin
               cs_n_d  = 1'b1;
               gap_d   = GW'(CS_GAP - 1);
               state_d = S_GAP_A;
            end
         end
         S_GAP_A: if (gap_q == '0) state_d = S_OP;
         S_OP: begin
            cs_n_d = 1'b0;
            if (bus.sh_done) begin
               idx_d = '0;
               if (has_addr_q)       state_d   = S_ADDR;
               else if (len_q == '0) frame_end = 1'b1;
               else                  state_d   = S_DATA;
            end
         end
         S_ADDR: begin
            if (bus.sh_done) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == 2'd2) begin
                  idx_d = '0;
                  if (len_q == '0) frame_end = 1'b1;
                  else             state_d   = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (bus.sh_done) begin
               if (read_q) begin
                  rd_data_d  = bus.sh_rx;
                  rd_valid_d = 1'b1;
               end
               len_d = len_q - 16'd1;
               if (len_q == 16'd1) frame_end = 1'b1;
            end
         end
         S_GAP_B: if (gap_q == '0) state_d = poll_q ? S_POLL : S_FIN;
         S_POLL: begin
            cs_n_d = 1'b0;
            if (bus.sh_done) begin
               if (idx_q == 2'd0) begin
                  idx_d = 2'd1;
               end else begin
                  idx_d    = '0;
                  cs_n_d   = 1'b1;
                  status_d = bus.sh_rx;
                  if (!bus.sh_rx[0]) begin
                     state_d = S_FIN;
                  end else if (poll_left_q == PW'(1)) begin
                     err_d   = 1'b1;
                     state_d = S_FIN;
                  end else begin
                     poll_left_d = poll_left_q - 1'b1;
                     gap_d       = GW'(CS_GAP - 1);
                     state_d     = S_GAP_P;
                  end
               end
            end
         end
         S_GAP_P: if (gap_q == '0) state_d = S_POLL;
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (frame_end) begin
         cs_n_d  = 1'b1;
         gap_d   = GW'(CS_GAP - 1);
         state_d = S_GAP_B;
      end

      // Abort lets an in-flight byte finish, then drops everything, including its read byte.
      if (bus.abort && state_q != S_IDLE && state_q != S_FIN) begin
         if (!(pend_q && !bus.sh_done)) begin
            state_d    = S_FIN;
            cs_n_d     = 1'b1;
            err_d      = 1'b1;
            rd_valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      // cs_n must already be low a cycle before any start; never start on a sh_done cycle.
      can_start = !cs_n_q && !pend_q && !bus.sh_done && !bus.abort;
      cmd_ready = 1'b0;
      sh_start  = 1'b0;
      sh_tx     = 8'h00;
      wr_ready  = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: cmd_ready = !rst && !bus.abort;
         S_WREN: begin
            sh_tx    = 8'h06;
            sh_start = can_start;
         end
         S_OP: begin
            sh_tx    = op_q;
            sh_start = can_start;
         end
         S_ADDR: begin
            case (idx_q)
               2'd0:    sh_tx = addr_q[23:16];
               2'd1:    sh_tx = addr_q[15:8];
               default: sh_tx = addr_q[7:0];
            endcase
            sh_start = can_start;
         end
         S_DATA: begin
            if (read_q) begin
               sh_start = can_start && !rd_valid_q;
            end else begin
               sh_tx    = bus.wr_data;
               sh_start = can_start && bus.wr_valid;
               wr_ready = sh_start;
            end
         end
         S_POLL: begin
            sh_tx    = (idx_q == 2'd0) ? 8'h05 : 8'h00;
            sh_start = can_start;
         end
         S_FIN: done = 1'b1;
         default: ;
      endcase
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.wr_ready  = wr_ready;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.sh_start  = sh_start;
   assign bus.sh_tx     = sh_tx;
   assign bus.cs_n      = cs_n_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done;
   assign bus.err       = err_q;
   assign bus.status    = status_q;
endmodule
